// File: rtl/character_move_ctl_if.sv
// Movement controller bus: map inputs, button levels and the
// registered character position/state outputs.
interface character_move_ctl_if;
    logic        frame_tick;
    logic        btn_left;
    logic        btn_right;
    logic        btn_up;
    logic        btn_down;
    logic        btn_jump;
    logic        ladder;
    logic [1:0]  platform;
    logic [10:0] limit_ypos_min;
    logic [10:0] limit_ypos_max;
    logic        end_of_platform;
    logic [10:0] landing_ypos;
    logic [10:0] xpos;
    logic [10:0] ypos;
    logic [1:0]  state;
    logic        facing_left;

    modport master (
        output frame_tick, btn_left, btn_right, btn_up, btn_down,
        output btn_jump, ladder, platform, limit_ypos_min,
        output limit_ypos_max, end_of_platform, landing_ypos,
        input  xpos, ypos, state, facing_left
    );

    modport slave (
        input  frame_tick, btn_left, btn_right, btn_up, btn_down,
        input  btn_jump, ladder, platform, limit_ypos_min,
        input  limit_ypos_max, end_of_platform, landing_ypos,
        output xpos, ypos, state, facing_left
    );
endinterface

// File: rtl/character_move_ctl.sv
// Per-frame character movement sequencer: GROUND / CLIMB / JUMP / FALL.
// Position, velocity and landing targets only change on frame_tick.
module character_move_ctl #(
    parameter int START_XPOS = 64,
    parameter int START_YPOS = 710,
    parameter int WALK_STEP  = 2,
    parameter int CLIMB_STEP = 2,
    parameter int JUMP_V0    = 12,
    parameter int GRAVITY    = 1,
    parameter int FALL_STEP  = 4,
    parameter int X_MAX      = 976
) (
    input logic clk,
    input logic rst,
    character_move_ctl_if.slave bus
);

    typedef enum logic [1:0] {
        GROUND = 2'b00,
        CLIMB  = 2'b01,
        JUMP   = 2'b10,
        FALL   = 2'b11
    } state_t;

    localparam logic [11:0]        XMAX  = 12'(X_MAX);
    localparam logic [11:0]        WSTEP = 12'(WALK_STEP);
    localparam logic signed [12:0] CSTEP = 13'(CLIMB_STEP);
    localparam logic signed [12:0] FSTEP = 13'(FALL_STEP);
    localparam logic signed [6:0]  GRAV  = 7'(GRAVITY);
    localparam logic signed [6:0]  VMIN  = -7'sd32;

    state_t             state_q, state_d;
    logic [10:0]        xpos_q, xpos_d, ypos_q, ypos_d;
    logic [10:0]        base_q, base_d, land_q, land_d;
    logic signed [5:0]  vel_q, vel_d;
    logic               facing_q, facing_d;

    logic               walk_l, walk_r, walk, ladder_req;
    logic               at_lim, land_hit, fall_hit, fall_done;
    logic [11:0]        x_ext, x_lft, x_rgt;
    logic [10:0]        x_walk;
    logic signed [12:0] y_ext, vel_ext, slope, y_slope, y_jump;
    logic signed [12:0] y_up, y_dn, y_fall;
    logic signed [12:0] min_ext, max_ext, base_ext, land_ext;
    logic signed [6:0]  vel_dec;
    logic signed [5:0]  vel_nx;

    // Clamp 13-bit signed y results into the 11-bit screen range.
    function automatic logic [10:0] sat_y(input logic signed [12:0] v);
        if (v < 13'sd0)
            sat_y = '0;
        else if (v > 13'sd2047)
            sat_y = 11'h7ff;
        else
            sat_y = v[10:0];
    endfunction

    assign walk_l     = bus.btn_left;
    assign walk_r     = bus.btn_right & ~bus.btn_left;
    assign walk       = bus.btn_left | bus.btn_right;
    assign ladder_req = bus.ladder & (bus.btn_up | bus.btn_down);

    assign x_ext  = {1'b0, xpos_q};
    assign x_lft  = (x_ext >= WSTEP) ? x_ext - WSTEP : 12'd0;
    assign x_rgt  = (x_ext + WSTEP > XMAX) ? XMAX : x_ext + WSTEP;
    assign x_walk = walk_l ? x_lft[10:0] : x_rgt[10:0];

    assign y_ext    = $signed({2'b00, ypos_q});
    assign min_ext  = $signed({2'b00, bus.limit_ypos_min});
    assign max_ext  = $signed({2'b00, bus.limit_ypos_max});
    assign base_ext = $signed({2'b00, base_q});
    assign land_ext = $signed({2'b00, land_q});
    assign vel_ext  = $signed({{7{vel_q[5]}}, vel_q});

    // Slope 01 rises to the left, 10 rises to the right.
    assign slope = (bus.platform == 2'b01) ? (walk_l ? -13'sd1 : 13'sd1) :
                   (bus.platform == 2'b10) ? (walk_l ? 13'sd1 : -13'sd1) :
                   13'sd0;
    assign y_slope = y_ext + slope;
    assign y_jump  = y_ext - vel_ext;
    assign y_up    = (y_ext - CSTEP < min_ext) ? min_ext : y_ext - CSTEP;
    assign y_dn    = (y_ext + CSTEP > max_ext) ? max_ext : y_ext + CSTEP;
    assign y_fall  = y_ext + FSTEP;

    assign at_lim    = (ypos_q == bus.limit_ypos_min) ||
                       (ypos_q == bus.limit_ypos_max);
    assign land_hit  = (vel_q < 6'sd0) && (y_jump >= base_ext);
    assign fall_hit  = bus.end_of_platform && (vel_q <= 6'sd0);
    assign fall_done = (y_fall >= land_ext);

    // Velocity saturates at the most negative 6-bit value.
    assign vel_dec = $signed({vel_q[5], vel_q}) - GRAV;
    assign vel_nx  = (vel_dec < VMIN) ? 6'sh20 : vel_dec[5:0];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= GROUND;
        else
            state_q <= state_d;
    end

    // Next-state selection on each frame tick.
    always_comb begin
        state_d = state_q;
        if (bus.frame_tick) begin
            unique case (state_q)
                GROUND: begin
                    if (ladder_req)
                        state_d = CLIMB;
                    else if (bus.btn_jump)
                        state_d = JUMP;
                    else if (bus.end_of_platform)
                        state_d = FALL;
                end
                CLIMB: begin
                    if (at_lim && walk)
                        state_d = GROUND;
                end
                JUMP: begin
                    if (land_hit)
                        state_d = GROUND;
                    else if (fall_hit)
                        state_d = FALL;
                end
                FALL: begin
                    if (fall_done)
                        state_d = GROUND;
                end
            endcase
        end
    end

    // Position, velocity and landing-target updates per state.
    always_comb begin
        xpos_d   = xpos_q;
        ypos_d   = ypos_q;
        vel_d    = vel_q;
        base_d   = base_q;
        land_d   = land_q;
        facing_d = facing_q;
        if (bus.frame_tick) begin
            unique case (state_q)
                GROUND: begin
                    if (ladder_req) begin
                        ypos_d = ypos_q;
                    end else if (bus.btn_jump) begin
                        vel_d  = 6'(JUMP_V0);
                        base_d = ypos_q;
                    end else if (bus.end_of_platform) begin
                        land_d = bus.landing_ypos;
                    end else if (walk) begin
                        xpos_d   = x_walk;
                        ypos_d   = sat_y(y_slope);
                        facing_d = walk_l;
                    end
                end
                CLIMB: begin
                    if (!(at_lim && walk)) begin
                        if (bus.btn_up)
                            ypos_d = sat_y(y_up);
                        else if (bus.btn_down)
                            ypos_d = sat_y(y_dn);
                    end
                end
                JUMP: begin
                    if (walk) begin
                        xpos_d   = x_walk;
                        facing_d = walk_l;
                    end
                    if (land_hit) begin
                        ypos_d = base_q;
                    end else if (fall_hit) begin
                        land_d = bus.landing_ypos;
                    end else begin
                        ypos_d = sat_y(y_jump);
                        vel_d  = vel_nx;
                    end
                end
                FALL: begin
                    if (fall_done)
                        ypos_d = land_q;
                    else
                        ypos_d = sat_y(y_fall);
                end
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xpos_q   <= 11'(START_XPOS);
            ypos_q   <= 11'(START_YPOS);
            vel_q    <= '0;
            base_q   <= '0;
            land_q   <= '0;
            facing_q <= 1'b0;
        end else begin
            xpos_q   <= xpos_d;
            ypos_q   <= ypos_d;
            vel_q    <= vel_d;
            base_q   <= base_d;
            land_q   <= land_d;
            facing_q <= facing_d;
        end
    end

    assign bus.xpos        = xpos_q;
    assign bus.ypos        = ypos_q;
    assign bus.state       = state_q;
    assign bus.facing_left = facing_q;

endmodule

// File: tb/tb_character_move_ctl.sv
// Bench for character_move_ctl: scripted vector table, async reset
// sequences, then random stimulus against a rule-level model.
module tb_character_move_ctl;

    localparam int L = 16, R = 8, U = 4, D = 2, J = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    character_move_ctl_if bus();

    character_move_ctl dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int btn, lad, plat, mn, mx, eop, land, n;
        int ex, ey, es, ef;
    } vec_t;

    vec_t tv[$];
    int n_chk = 0;
    int n_err = 0;

    int m_x, m_y, m_v, m_base, m_land, m_st, m_f;

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_in(input int btn, input int lad, input int plat,
                          input int mn, input int mx, input int eop,
                          input int land);
        bus.btn_left        = btn[4];
        bus.btn_right       = btn[3];
        bus.btn_up          = btn[2];
        bus.btn_down        = btn[1];
        bus.btn_jump        = btn[0];
        bus.ladder          = lad[0];
        bus.platform        = plat[1:0];
        bus.limit_ypos_min  = mn[10:0];
        bus.limit_ypos_max  = mx[10:0];
        bus.end_of_platform = eop[0];
        bus.landing_ypos    = land[10:0];
    endtask

    task automatic tick();
        @(negedge clk) bus.frame_tick = 1'b1;
        @(negedge clk) bus.frame_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_x = 64; m_y = 710; m_v = 0; m_base = 0;
        m_land = 0; m_st = 0; m_f = 0;
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        model_reset();
    endtask

    function automatic int clampy(input int v);
        if (v < 0) return 0;
        if (v > 2047) return 2047;
        return v;
    endfunction

    task automatic m_walk(input bit l);
        if (l) begin
            m_x = (m_x - 2 < 0) ? 0 : m_x - 2;
            m_f = 1;
        end else begin
            m_x = (m_x + 2 > 976) ? 976 : m_x + 2;
            m_f = 0;
        end
    endtask

    task automatic model_step(input int btn, input int lad, input int plat,
                              input int mn, input int mx, input int eop,
                              input int land);
        bit l, r, u, d, j;
        int ny, dy;
        l = btn[4]; r = btn[3]; u = btn[2]; d = btn[1]; j = btn[0];
        case (m_st)
            0: begin
                if (lad != 0 && (u || d)) m_st = 1;
                else if (j) begin m_st = 2; m_v = 12; m_base = m_y; end
                else if (eop != 0) begin m_st = 3; m_land = land; end
                else if (l || r) begin
                    m_walk(l);
                    dy = 0;
                    if (plat == 1) dy = l ? -1 : 1;
                    else if (plat == 2) dy = l ? 1 : -1;
                    m_y = clampy(m_y + dy);
                end
            end
            1: begin
                if ((m_y == mn || m_y == mx) && (l || r)) m_st = 0;
                else if (u) m_y = clampy((m_y - 2 < mn) ? mn : m_y - 2);
                else if (d) m_y = clampy((m_y + 2 > mx) ? mx : m_y + 2);
            end
            2: begin
                if (l || r) m_walk(l);
                ny = m_y - m_v;
                if (m_v < 0 && ny >= m_base) begin
                    m_y = m_base; m_st = 0;
                end else if (eop != 0 && m_v <= 0) begin
                    m_st = 3; m_land = land;
                end else begin
                    m_y = clampy(ny);
                    m_v = (m_v > -32) ? m_v - 1 : -32;
                end
            end
            default: begin
                if (m_y + 4 >= m_land) begin m_y = m_land; m_st = 0; end
                else m_y = clampy(m_y + 4);
            end
        endcase
    endtask

    initial begin
        int btn, lad, plat, mn, mx, eop, land;
        rst = 1'b0;
        bus.frame_tick = 1'b0;
        set_in(0, 0, 0, 500, 710, 0, 603);

        // btn lad plat mn mx eop land n | x y state facing
        tv.push_back('{0,     0,0,500,710,0,603,  0,  64,710,0,0});
        tv.push_back('{R,     0,0,500,710,0,603, 10,  84,710,0,0});
        tv.push_back('{L|R,   0,0,500,710,0,603,  1,  82,710,0,1});
        tv.push_back('{R,     0,1,500,710,0,603,  1,  84,711,0,0});
        tv.push_back('{L,     0,1,500,710,0,603,  1,  82,710,0,1});
        tv.push_back('{R,     0,2,500,710,0,603,  1,  84,709,0,0});
        tv.push_back('{L,     0,2,500,710,0,603,  1,  82,710,0,1});
        tv.push_back('{U,     0,0,500,710,0,603,  3,  82,710,0,1});
        tv.push_back('{J,     0,0,500,710,0,603,  1,  82,710,2,1});
        tv.push_back('{0,     0,0,500,710,0,603,  1,  82,698,2,1});
        tv.push_back('{0,     0,0,500,710,0,603,  1,  82,687,2,1});
        tv.push_back('{0,     0,0,500,710,0,603,  1,  82,677,2,1});
        tv.push_back('{0,     0,0,500,710,0,603, 21,  82,698,2,1});
        tv.push_back('{0,     0,0,500,710,0,603,  1,  82,710,0,1});
        tv.push_back('{U|J,   1,0,500,710,0,603,  1,  82,710,1,1});
        tv.push_back('{U,     1,0,500,710,0,603,200,  82,500,1,1});
        tv.push_back('{R,     1,0,500,710,0,603,  1,  82,500,0,1});
        tv.push_back('{U,     1,0,475,710,0,603,  1,  82,500,1,1});
        tv.push_back('{U,     1,0,475,710,0,603, 20,  82,475,1,1});
        tv.push_back('{R,     1,0,475,710,0,603,  1,  82,475,0,1});
        tv.push_back('{0,     0,0,475,710,1,603,  1,  82,475,3,1});
        tv.push_back('{0,     0,0,475,710,0,100, 31,  82,599,3,1});
        tv.push_back('{0,     0,0,475,710,0,100,  1,  82,603,0,1});
        tv.push_back('{R,     0,0,475,710,0,100,446, 974,603,0,0});
        tv.push_back('{R,     0,0,475,710,0,100,  1, 976,603,0,0});
        tv.push_back('{R,     0,0,475,710,0,100,  2, 976,603,0,0});
        tv.push_back('{L,     0,0,475,710,0,100,  1, 974,603,0,1});
        tv.push_back('{L,     0,0,475,710,0,100,500,   0,603,0,1});
        tv.push_back('{L,     0,0,475,710,0,100,  1,   0,603,0,1});
        tv.push_back('{U,     1,0,500,603,0,100,  1,   0,603,1,1});
        tv.push_back('{D,     1,0,500,603,0,100,  2,   0,603,1,1});
        tv.push_back('{U|D,   1,0,500,603,0,100,  1,   0,601,1,1});
        tv.push_back('{L,     1,0,500,603,0,100,  1,   0,601,1,1});
        tv.push_back('{D,     1,0,500,603,0,100,  1,   0,603,1,1});
        tv.push_back('{L,     1,0,500,603,0,100,  1,   0,603,0,1});
        tv.push_back('{J,     0,0,500,603,0,100,  1,   0,603,2,1});
        tv.push_back('{0,     0,0,500,603,1,700, 12,   0,525,2,1});
        tv.push_back('{0,     0,0,500,603,1,700,  1,   0,525,3,1});
        tv.push_back('{0,     0,0,500,603,0,900, 43,   0,697,3,1});
        tv.push_back('{0,     0,0,500,603,0,900,  1,   0,700,0,1});
        tv.push_back('{J|R,   0,0,500,603,0,900,  1,   0,700,2,1});
        tv.push_back('{R,     0,0,500,603,0,900,  2,   4,677,2,0});
        tv.push_back('{0,     0,0,500,603,0,900, 23,   4,700,0,0});

        do_reset();
        for (int i = 0; i < tv.size(); i++) begin
            set_in(tv[i].btn, tv[i].lad, tv[i].plat, tv[i].mn,
                   tv[i].mx, tv[i].eop, tv[i].land);
            repeat (tv[i].n) tick();
            chk($sformatf("vec%0d_xpos", i), int'(bus.xpos), tv[i].ex);
            chk($sformatf("vec%0d_ypos", i), int'(bus.ypos), tv[i].ey);
            chk($sformatf("vec%0d_state", i), int'(bus.state), tv[i].es);
            chk($sformatf("vec%0d_facing", i), int'(bus.facing_left),
                tv[i].ef);
        end

        // Buttons alone, without frame_tick, must not move anything.
        set_in(R, 0, 0, 500, 710, 0, 900);
        repeat (5) @(negedge clk);
        chk("hold_no_tick_xpos", int'(bus.xpos), 4);

        // Async reset mid-jump, checked before the next clock edge.
        set_in(J, 0, 0, 500, 710, 0, 900);
        tick();
        set_in(0, 0, 0, 500, 710, 0, 900);
        repeat (3) tick();
        chk("midjump_ypos", int'(bus.ypos), 667);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_xpos", int'(bus.xpos), 64);
        chk("async_rst_ypos", int'(bus.ypos), 710);
        chk("async_rst_state", int'(bus.state), 0);
        @(negedge clk) rst = 1'b0;
        set_in(J, 0, 0, 500, 710, 0, 900);
        tick();
        set_in(0, 0, 0, 500, 710, 0, 900);
        tick();
        chk("post_rst_jump_ypos", int'(bus.ypos), 698);

        // Async reset in the middle of a walk sequence.
        do_reset();
        set_in(R, 0, 0, 500, 710, 0, 900);
        repeat (5) tick();
        chk("walk5_xpos", int'(bus.xpos), 74);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_walk_xpos", int'(bus.xpos), 64);
        @(negedge clk) rst = 1'b0;

        mn = 500; mx = 710;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) do_reset();
            if (i % 40 == 0) begin
                mn = $urandom_range(300, 650);
                mx = $urandom_range(mn + 10, 800);
            end
            btn  = $urandom_range(0, 31);
            lad  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            plat = $urandom_range(0, 3);
            eop  = ($urandom_range(0, 7) == 0) ? 1 : 0;
            land = $urandom_range(300, 1000);
            set_in(btn, lad, plat, mn, mx, eop, land);
            model_step(btn, lad, plat, mn, mx, eop, land);
            tick();
            chk($sformatf("rnd%0d_xpos", i), int'(bus.xpos), m_x);
            chk($sformatf("rnd%0d_ypos", i), int'(bus.ypos), m_y);
            chk($sformatf("rnd%0d_state", i), int'(bus.state), m_st);
            chk($sformatf("rnd%0d_facing", i), int'(bus.facing_left), m_f);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
